// File: rtl/y86_pkg.sv
// y86_pkg: shared Y86-64 encodings and controller types
package y86_pkg;
   localparam logic [3:0] ICMOVXX = 4'd2;
   localparam logic [3:0] IMRMOVQ = 4'd5;
   localparam logic [3:0] IOPQ    = 4'd6;
   localparam logic [3:0] IJXX    = 4'd7;
   localparam logic [3:0] IRET    = 4'd9;
   localparam logic [3:0] IPOPQ   = 4'd11;
   localparam logic [3:0] RNONE   = 4'd15;
   localparam logic [2:0] SAOK    = 3'd1;
   localparam logic [2:0] SHLT    = 3'd2;
   localparam logic [2:0] SADR    = 3'd3;
   localparam logic [2:0] SINS    = 3'd4;
   typedef enum logic [3:0] {C_ALL, C_LE, C_L, C_E, C_NE, C_GE, C_G} cond_t;
   typedef enum logic [1:0] {RUN, DRAIN, HALTED} ctrl_state_t;
   function automatic logic is_exc(input logic [2:0] s);
      return s == SHLT || s == SADR || s == SINS;
   endfunction
endpackage

// File: rtl/pipe_control_cc_unit.sv
// cc_unit: architectural condition codes and jXX/cmovXX condition evaluation
module cc_unit
   import y86_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       set_cc,
   input  logic       alu_zf,
   input  logic       alu_sf,
   input  logic       alu_of,
   input  logic [3:0] ifun,
   output logic       cc_zf,
   output logic       cc_sf,
   output logic       cc_of,
   output logic       e_cnd
);
   logic [2:0] cc_q;
   logic       lt;
   // condition codes load from the ALU only when the OPq is allowed to commit
   always_ff @(posedge clk)
      if (rst) cc_q <= 3'b100;
      else if (set_cc) cc_q <= {alu_zf, alu_sf, alu_of};
   // condition is decoded from the stored flags, never the in-flight ALU flags
   always_comb begin
      {cc_zf, cc_sf, cc_of} = cc_q;
      lt = cc_sf ^ cc_of;
      e_cnd = ifun == C_ALL ? 1'b1 :
              ifun == C_LE  ? lt | cc_zf :
              ifun == C_L   ? lt :
              ifun == C_E   ? cc_zf :
              ifun == C_NE  ? !cc_zf :
              ifun == C_GE  ? !lt :
              ifun == C_G   ? !lt && !cc_zf : 1'b0;
   end
endmodule

// File: rtl/pipe_control.sv
// pipe_control: Y86-64 hazard control, halt sequencing and performance counters
module pipe_control
   import y86_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       D_icode,
   input  logic [3:0]       d_srcA,
   input  logic [3:0]       d_srcB,
   input  logic [3:0]       E_icode,
   input  logic [3:0]       E_ifun,
   input  logic [3:0]       E_dstM,
   input  logic [3:0]       M_icode,
   input  logic             alu_zf,
   input  logic             alu_sf,
   input  logic             alu_of,
   input  logic [2:0]       m_stat,
   input  logic [2:0]       W_stat,
   output logic             e_Cnd,
   output logic             cc_zf,
   output logic             cc_sf,
   output logic             cc_of,
   output logic             F_stall,
   output logic             D_stall,
   output logic             D_bubble,
   output logic             E_bubble,
   output logic             M_bubble,
   output logic             W_stall,
   output logic             halted,
   output logic [2:0]       halt_stat,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] bubble_cnt
);
   ctrl_state_t      state_q;
   logic             halted_q;
   logic [2:0]       halt_stat_q;
   logic [CNT_W-1:0] cycle_q, cycle_d, bubble_q, bubble_d;
   logic             lu, rt, mp, exc_m, exc_w, hlt, set_cc;

   cc_unit u_cc (
      .clk    (clk),
      .rst    (rst),
      .set_cc (set_cc),
      .alu_zf (alu_zf),
      .alu_sf (alu_sf),
      .alu_of (alu_of),
      .ifun   (E_ifun),
      .cc_zf  (cc_zf),
      .cc_sf  (cc_sf),
      .cc_of  (cc_of),
      .e_cnd  (e_Cnd)
   );

   // hazard detection and pipeline-register controls; reset and halt override the equations
   always_comb begin
      lu = (E_icode == IMRMOVQ || E_icode == IPOPQ) && E_dstM != RNONE &&
           (E_dstM == d_srcA || E_dstM == d_srcB);
      rt = D_icode == IRET || E_icode == IRET || M_icode == IRET;
      mp = E_icode == IJXX && !e_Cnd;
      exc_m = is_exc(m_stat);
      exc_w = is_exc(W_stat);
      hlt = state_q == HALTED;
      set_cc = E_icode == IOPQ && m_stat == SAOK && W_stat == SAOK && state_q == RUN;
      F_stall = rst ? 1'b0 : hlt ? 1'b1 : lu | rt;
      D_stall = rst ? 1'b0 : hlt ? 1'b1 : lu;
      D_bubble = rst ? 1'b1 : hlt ? 1'b0 : mp | (rt & !lu);
      E_bubble = rst ? 1'b1 : hlt ? 1'b0 : mp | lu;
      M_bubble = rst ? 1'b1 : hlt ? 1'b0 : exc_m | exc_w;
      W_stall = rst ? 1'b0 : hlt ? 1'b1 : exc_w;
      cycle_d = cycle_q + CNT_W'(1);
      bubble_d = bubble_q + CNT_W'(E_bubble);
   end

   // halt sequencer: an exception reaching writeback stops the machine until reset
   always_ff @(posedge clk)
      if (rst) begin
         state_q <= RUN;
         halted_q <= 1'b0;
         halt_stat_q <= SAOK;
      end else if (state_q != HALTED && exc_w) begin
         state_q <= HALTED;
         halted_q <= 1'b1;
         halt_stat_q <= W_stat;
      end else if (state_q == RUN && exc_m) state_q <= DRAIN;

   // performance counters freeze once halted and wrap naturally
   always_ff @(posedge clk)
      if (rst) begin
         cycle_q <= '0;
         bubble_q <= '0;
      end else if (!hlt) begin
         cycle_q <= cycle_d;
         bubble_q <= bubble_d;
      end

   assign halted = halted_q;
   assign halt_stat = halt_stat_q;
   assign cycle_cnt = cycle_q;
   assign bubble_cnt = bubble_q;
endmodule

// File: tb/tb_pipe_control.sv
// tb_pipe_control: scenario tasks with a scoreboard of registered expectations
module tb_pipe_control;
   logic clk = 1'b0, rst = 1'b1;
   logic [3:0] D_icode, d_srcA, d_srcB, E_icode, E_ifun, E_dstM, M_icode;
   logic alu_zf, alu_sf, alu_of;
   logic [2:0] m_stat, W_stat;
   logic e_Cnd, cc_zf, cc_sf, cc_of, F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, halted;
   logic [2:0] halt_stat;
   logic [31:0] cycle_cnt, bubble_cnt;
   logic w_cnd, w_zf, w_sf, w_of, w_fs, w_ds, w_db, w_eb, w_mb, w_ws, w_h;
   logic [2:0] w_hs;
   logic [3:0] w_cyc, w_bub;
   logic [5:0] ctrl;
   logic [2:0] cc;
   logic [31:0] exp_cyc;
   logic exp_halted;
   int errors = 0, checks = 0;
   typedef struct packed { logic [2:0] cc; logic halted; logic [2:0] hstat; } exp_t;
   exp_t sb_q[$];
   exp_t e;

   always #5 clk = ~clk;
   assign ctrl = {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall};
   assign cc = {cc_zf, cc_sf, cc_of};

   pipe_control #(.CNT_W(32)) dut (
      .clk(clk), .rst(rst), .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
      .E_icode(E_icode), .E_ifun(E_ifun), .E_dstM(E_dstM), .M_icode(M_icode),
      .alu_zf(alu_zf), .alu_sf(alu_sf), .alu_of(alu_of), .m_stat(m_stat), .W_stat(W_stat),
      .e_Cnd(e_Cnd), .cc_zf(cc_zf), .cc_sf(cc_sf), .cc_of(cc_of), .F_stall(F_stall),
      .D_stall(D_stall), .D_bubble(D_bubble), .E_bubble(E_bubble), .M_bubble(M_bubble),
      .W_stall(W_stall), .halted(halted), .halt_stat(halt_stat), .cycle_cnt(cycle_cnt),
      .bubble_cnt(bubble_cnt));

   pipe_control #(.CNT_W(4)) u_w (
      .clk(clk), .rst(rst), .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
      .E_icode(E_icode), .E_ifun(E_ifun), .E_dstM(E_dstM), .M_icode(M_icode),
      .alu_zf(alu_zf), .alu_sf(alu_sf), .alu_of(alu_of), .m_stat(m_stat), .W_stat(W_stat),
      .e_Cnd(w_cnd), .cc_zf(w_zf), .cc_sf(w_sf), .cc_of(w_of), .F_stall(w_fs),
      .D_stall(w_ds), .D_bubble(w_db), .E_bubble(w_eb), .M_bubble(w_mb),
      .W_stall(w_ws), .halted(w_h), .halt_stat(w_hs), .cycle_cnt(w_cyc),
      .bubble_cnt(w_bub));

   task automatic idle();
      D_icode = 4'd1; E_icode = 4'd1; M_icode = 4'd1; E_ifun = 4'd0;
      d_srcA = 4'd15; d_srcB = 4'd15; E_dstM = 4'd15;
      alu_zf = 1'b0; alu_sf = 1'b0; alu_of = 1'b0; m_stat = 3'd1; W_stat = 3'd1;
   endtask

   task automatic step();
      @(posedge clk);
      if (rst) begin exp_cyc = 0; exp_halted = 1'b0; end
      else if (!exp_halted) exp_cyc = exp_cyc + 1;
      #1;
   endtask

   task automatic reset_dut();
      rst = 1'b1; step(); step(); rst = 1'b0;
   endtask

   task automatic test_reset();
      idle(); exp_cyc = 0; exp_halted = 1'b0;
      step(); step();
      checks++; if (ctrl !== 6'b001110) begin errors++; $display("FAIL rst_ctrl got %b exp 001110", ctrl); end
      checks++; if (cc !== 3'b100) begin errors++; $display("FAIL rst_cc got %b exp 100", cc); end
      checks++; if (halted !== 1'b0 || halt_stat !== 3'd1) begin errors++; $display("FAIL rst_halt got %b/%0d exp 0/1", halted, halt_stat); end
      checks++; if (cycle_cnt !== 0 || bubble_cnt !== 0) begin errors++; $display("FAIL rst_cnt got %0d/%0d exp 0/0", cycle_cnt, bubble_cnt); end
      rst = 1'b0; #1;
      checks++; if (ctrl !== 6'b000000) begin errors++; $display("FAIL idle_ctrl got %b exp 000000", ctrl); end
   endtask

   task automatic test_cc();
      E_icode = 4'd6; alu_zf = 1'b0; alu_sf = 1'b1; alu_of = 1'b0;
      sb_q.push_back('{cc: 3'b010, halted: 1'b0, hstat: 3'd1});
      step(); e = sb_q.pop_front();
      checks++; if (cc !== e.cc) begin errors++; $display("FAIL opq_cc got %b exp %b", cc, e.cc); end
      E_icode = 4'd7;
      E_ifun = 4'd2; #1;
      checks++; if (e_Cnd !== 1'b1) begin errors++; $display("FAIL cnd_l got %b exp 1", e_Cnd); end
      E_ifun = 4'd5; #1;
      checks++; if (e_Cnd !== 1'b0) begin errors++; $display("FAIL cnd_ge got %b exp 0", e_Cnd); end
      E_ifun = 4'd3; #1;
      checks++; if (e_Cnd !== 1'b0) begin errors++; $display("FAIL cnd_e got %b exp 0", e_Cnd); end
      E_ifun = 4'd4; #1;
      checks++; if (e_Cnd !== 1'b1) begin errors++; $display("FAIL cnd_ne got %b exp 1", e_Cnd); end
      E_ifun = 4'd7; #1;
      checks++; if (e_Cnd !== 1'b0) begin errors++; $display("FAIL cnd_bad got %b exp 0", e_Cnd); end
      E_icode = 4'd6; E_ifun = 4'd0; alu_zf = 1'b1; alu_sf = 1'b0; m_stat = 3'd3;
      sb_q.push_back('{cc: 3'b010, halted: 1'b0, hstat: 3'd1});
      step(); e = sb_q.pop_front();
      checks++; if (cc !== e.cc) begin errors++; $display("FAIL exc_cc_hold got %b exp %b", cc, e.cc); end
      idle(); reset_dut();
   endtask

   task automatic test_load_use();
      E_icode = 4'd5; E_dstM = 4'd3; d_srcB = 4'd3; #1;
      checks++; if (ctrl !== 6'b110100) begin errors++; $display("FAIL lu_mrm got %b exp 110100", ctrl); end
      D_icode = 4'd9; #1;
      checks++; if (ctrl !== 6'b110100) begin errors++; $display("FAIL lu_ret got %b exp 110100", ctrl); end
      D_icode = 4'd1; E_icode = 4'd11; E_dstM = 4'd4; d_srcA = 4'd4; d_srcB = 4'd15; #1;
      checks++; if (ctrl !== 6'b110100) begin errors++; $display("FAIL lu_pop got %b exp 110100", ctrl); end
      E_icode = 4'd5; E_dstM = 4'd15; d_srcA = 4'd15; #1;
      checks++; if (ctrl !== 6'b000000) begin errors++; $display("FAIL lu_rnone got %b exp 000000", ctrl); end
      idle();
   endtask

   task automatic test_mispredict();
      E_icode = 4'd6;
      sb_q.push_back('{cc: 3'b000, halted: 1'b0, hstat: 3'd1});
      step(); e = sb_q.pop_front();
      checks++; if (cc !== e.cc) begin errors++; $display("FAIL mp_cc got %b exp %b", cc, e.cc); end
      E_icode = 4'd7; E_ifun = 4'd3; #1;
      checks++; if (e_Cnd !== 1'b0 || ctrl !== 6'b001100) begin errors++; $display("FAIL mp_ctrl got %b/%b exp 0/001100", e_Cnd, ctrl); end
      step(); step(); step();
      checks++; if (bubble_cnt !== 32'd3) begin errors++; $display("FAIL mp_bcnt got %0d exp 3", bubble_cnt); end
      E_ifun = 4'd0; #1;
      checks++; if (ctrl !== 6'b000000) begin errors++; $display("FAIL jmp_taken got %b exp 000000", ctrl); end
      E_icode = 4'd1; D_icode = 4'd9; #1;
      checks++; if (ctrl !== 6'b101000) begin errors++; $display("FAIL ret got %b exp 101000", ctrl); end
      idle();
   endtask

   task automatic test_halt();
      m_stat = 3'd2; #1;
      checks++; if (ctrl !== 6'b000010) begin errors++; $display("FAIL m_exc got %b exp 000010", ctrl); end
      step(); m_stat = 3'd1; W_stat = 3'd2; #1;
      checks++; if (ctrl !== 6'b000011 || halted !== 1'b0) begin errors++; $display("FAIL w_exc got %b/%b exp 000011/0", ctrl, halted); end
      sb_q.push_back('{cc: 3'b000, halted: 1'b1, hstat: 3'd2});
      step(); exp_halted = 1'b1; e = sb_q.pop_front();
      checks++; if (halted !== e.halted || halt_stat !== e.hstat) begin errors++; $display("FAIL halt got %b/%0d exp %b/%0d", halted, halt_stat, e.halted, e.hstat); end
      checks++; if (cycle_cnt !== exp_cyc) begin errors++; $display("FAIL halt_cyc got %0d exp %0d", cycle_cnt, exp_cyc); end
      checks++; if (ctrl !== 6'b110001) begin errors++; $display("FAIL halt_ctrl got %b exp 110001", ctrl); end
      W_stat = 3'd1; E_icode = 4'd6; alu_zf = 1'b1; alu_sf = 1'b1; alu_of = 1'b1;
      sb_q.push_back('{cc: 3'b000, halted: 1'b1, hstat: 3'd2});
      for (int i = 0; i < 10; i++) step();
      e = sb_q.pop_front();
      checks++; if (cc !== e.cc || halted !== e.halted || halt_stat !== e.hstat) begin errors++; $display("FAIL frozen got %b/%b/%0d exp %b/%b/%0d", cc, halted, halt_stat, e.cc, e.halted, e.hstat); end
      checks++; if (cycle_cnt !== exp_cyc || bubble_cnt !== 32'd3) begin errors++; $display("FAIL frozen_cnt got %0d/%0d exp %0d/3", cycle_cnt, bubble_cnt, exp_cyc); end
      idle();
   endtask

   task automatic test_reset_drain();
      reset_dut();
      m_stat = 3'd3; step(); m_stat = 3'd1;
      checks++; if (halted !== 1'b0) begin errors++; $display("FAIL drain got %b exp 0", halted); end
      rst = 1'b1; step(); rst = 1'b0;
      checks++; if (halted !== 1'b0 || halt_stat !== 3'd1 || cc !== 3'b100) begin errors++; $display("FAIL drain_rst got %b/%0d/%b exp 0/1/100", halted, halt_stat, cc); end
      E_icode = 4'd6; alu_zf = 1'b0; alu_sf = 1'b1; alu_of = 1'b1;
      sb_q.push_back('{cc: 3'b011, halted: 1'b0, hstat: 3'd1});
      step(); e = sb_q.pop_front();
      checks++; if (cc !== e.cc) begin errors++; $display("FAIL run_cc got %b exp %b", cc, e.cc); end
      E_icode = 4'd1; W_stat = 3'd4;
      sb_q.push_back('{cc: 3'b011, halted: 1'b1, hstat: 3'd4});
      step(); exp_halted = 1'b1; e = sb_q.pop_front();
      checks++; if (halted !== e.halted || halt_stat !== e.hstat) begin errors++; $display("FAIL direct_halt got %b/%0d exp %b/%0d", halted, halt_stat, e.halted, e.hstat); end
      idle();
   endtask

   task automatic test_wrap();
      reset_dut();
      for (int i = 0; i < 15; i++) step();
      checks++; if (w_cyc !== 4'd15) begin errors++; $display("FAIL wrap15 got %0d exp 15", w_cyc); end
      step();
      checks++; if (w_cyc !== 4'd0) begin errors++; $display("FAIL wrap0 got %0d exp 0", w_cyc); end
      checks++; if (cycle_cnt !== exp_cyc) begin errors++; $display("FAIL cyc32 got %0d exp %0d", cycle_cnt, exp_cyc); end
   endtask

   initial begin
      test_reset();
      test_cc();
      test_load_use();
      test_mispredict();
      test_halt();
      test_reset_drain();
      test_wrap();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
